// File: rtl/uart_rx_deserializer.sv
// 16x-oversampling UART receiver feeding the RX FIFO: validates start/parity/stop,
// emits each good character with a one-clock Data_Rdy strobe and per-frame error status.
module uart_rx_deserializer #(
   parameter int DATA_BITS  = 8,
   parameter int BAUD_DIV   = 27,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 Rx_Serial,
   input  logic                 BIST_Mode,
   output logic [DATA_BITS-1:0] Rx_Data,
   output logic                 Data_Rdy,
   output logic                 Parity_Err,
   output logic                 Frame_Err,
   output logic                 Rx_Busy
);

   localparam int PW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
   localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
   } state_t;

   state_t               state_q, state_d;
   logic                 sync1_q, rx_s_q;
   logic [PW-1:0]        presc_q, presc_d;
   logic [3:0]           tcnt_q, tcnt_d;
   logic [IW-1:0]        bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_bit_q, par_bit_d;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 data_rdy_q, data_rdy_d;
   logic                 parity_err_q, parity_err_d;
   logic                 frame_err_q, frame_err_d;

   logic tick, mid_bit, mid_start, last_bit, par_bad;

   assign tick      = (presc_q == PW'(BAUD_DIV - 1));
   assign mid_start = tick && (tcnt_q == 4'd7);
   // After the start bit the tick counter is realigned, so count 15 lands mid-bit.
   assign mid_bit   = tick && (tcnt_q == 4'd15);
   assign last_bit  = (bit_idx_q == IW'(DATA_BITS - 1));
   assign par_bad   = (PARITY_EN != 0) && (par_bit_q != ((^shift_q) ^ PARITY_ODD[0]));

   // State register plus datapath flops
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         sync1_q      <= 1'b1;
         rx_s_q       <= 1'b1;
         presc_q      <= '0;
         tcnt_q       <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         par_bit_q    <= 1'b0;
         rx_data_q    <= '0;
         data_rdy_q   <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         sync1_q      <= Rx_Serial;
         rx_s_q       <= sync1_q;
         presc_q      <= presc_d;
         tcnt_q       <= tcnt_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         par_bit_q    <= par_bit_d;
         rx_data_q    <= rx_data_d;
         data_rdy_q   <= data_rdy_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (BIST_Mode) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:   if (!rx_s_q) state_d = S_START;
            S_START:  if (mid_start) state_d = rx_s_q ? S_IDLE : S_DATA;
            S_DATA:   if (mid_bit && last_bit) state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (mid_bit) state_d = S_STOP;
            S_STOP:   if (mid_bit) state_d = rx_s_q ? S_IDLE : S_BREAK;
            S_BREAK:  if (rx_s_q) state_d = S_IDLE;
            default:  state_d = S_IDLE;
         endcase
      end
   end

   // Datapath and output logic
   always_comb begin
      presc_d      = tick ? '0 : presc_q + 1'b1;
      tcnt_d       = tick ? tcnt_q + 4'd1 : tcnt_q;
      bit_idx_d    = bit_idx_q;
      shift_d      = shift_q;
      par_bit_d    = par_bit_q;
      rx_data_d    = rx_data_q;
      data_rdy_d   = 1'b0;
      parity_err_d = parity_err_q;
      frame_err_d  = frame_err_q;

      case (state_q)
         S_IDLE: begin
            presc_d = '0;
            tcnt_d  = '0;
         end
         S_START: if (mid_start && !rx_s_q) tcnt_d = '0;
         S_DATA: if (mid_bit) begin
            shift_d                = shift_q >> 1;
            shift_d[DATA_BITS-1]   = rx_s_q;
            bit_idx_d              = last_bit ? '0 : bit_idx_q + 1'b1;
         end
         S_PARITY: if (mid_bit) par_bit_d = rx_s_q;
         S_STOP: if (mid_bit) begin
            parity_err_d = par_bad;
            frame_err_d  = !rx_s_q;
            if (!par_bad && rx_s_q) begin
               rx_data_d  = shift_q;
               data_rdy_d = 1'b1;
            end
         end
         default: ;
      endcase

      if (BIST_Mode) begin
         presc_d    = '0;
         tcnt_d     = '0;
         bit_idx_d  = '0;
         shift_d    = '0;
         data_rdy_d = 1'b0;
         rx_data_d  = rx_data_q;
         parity_err_d = parity_err_q;
         frame_err_d  = frame_err_q;
      end
   end

   assign Rx_Data    = rx_data_q;
   assign Data_Rdy   = data_rdy_q;
   assign Parity_Err = parity_err_q;
   assign Frame_Err  = frame_err_q;
   assign Rx_Busy    = (state_q != S_IDLE);

endmodule
